// File: rtl/ysyx_23060332_ifu_pkg.sv
// ysyx_23060332_ifu_pkg
//   Shared types and constants for the instruction fetch unit.
//   - INST_W / INST_ADDR_W : instruction word and instruction address widths
//   - INST_NOP             : value presented on inst_o before the first fetch
//   - PC_RESET             : default PC after reset
//   - ifu_state_e          : 3-bit fetch FSM state encoding
//   - is_misaligned()      : true when an address is not word aligned
package ysyx_23060332_ifu_pkg;

    localparam int INST_W      = 32;
    localparam int INST_ADDR_W = 32;

    localparam logic [INST_W-1:0]      INST_NOP = 32'h0000_0013;
    localparam logic [INST_ADDR_W-1:0] PC_RESET = 32'h8000_0000;

    typedef enum logic [2:0] {
        IFU_S_IDLE  = 3'd0,
        IFU_S_REQ   = 3'd1,
        IFU_S_WAIT  = 3'd2,
        IFU_S_HOLD  = 3'd3,
        IFU_S_FAULT = 3'd4
    } ifu_state_e;

    function automatic logic is_misaligned(input logic [INST_ADDR_W-1:0] addr);
        return addr[1:0] != 2'b00;
    endfunction

endpackage

// File: rtl/ysyx_23060332_ifu_if.sv
// ysyx_23060332_ifu_if
//   Bundle of every handshake/bus signal around the fetch unit.
//   Handshake rule (both imem request and inst channels): a transfer happens
//   on a rising clock edge where valid && ready; once valid is raised the
//   producer holds valid and its payload stable until that transfer.
//   imem responses have no ready: a response is consumed whenever it is
//   expected and dropped otherwise.
//   modport master : the fetch unit's view (drives requests, instructions,
//                    fault status)
//   modport slave  : the environment's view (memory + decode/execute)
interface ysyx_23060332_ifu_if;
    import ysyx_23060332_ifu_pkg::*;

    logic                   imem_req_valid;
    logic                   imem_req_ready;
    logic [INST_ADDR_W-1:0] imem_req_addr;
    logic                   imem_resp_valid;
    logic [INST_W-1:0]      imem_resp_data;
    logic                   imem_resp_err;
    logic                   inst_valid;
    logic                   inst_ready;
    logic [INST_W-1:0]      inst_o;
    logic [INST_ADDR_W-1:0] inst_addr;
    logic                   jump_en;
    logic [INST_ADDR_W-1:0] jump_addr;
    logic                   fetch_fault;
    logic [INST_ADDR_W-1:0] fault_addr;

    modport master (
        output imem_req_valid, imem_req_addr,
        input  imem_req_ready,
        input  imem_resp_valid, imem_resp_data, imem_resp_err,
        output inst_valid, inst_o, inst_addr,
        input  inst_ready, jump_en, jump_addr,
        output fetch_fault, fault_addr
    );

    modport slave (
        input  imem_req_valid, imem_req_addr,
        output imem_req_ready,
        output imem_resp_valid, imem_resp_data, imem_resp_err,
        input  inst_valid, inst_o, inst_addr,
        output inst_ready, jump_en, jump_addr,
        input  fetch_fault, fault_addr
    );

endinterface

// File: rtl/ysyx_23060332_ifu_pc.sv
// ysyx_23060332_ifu_pc
//   Program counter register and next-PC selection.
//   Ports:
//     clk, rst_n : clock, asynchronous active-low reset (pc <= RESET_PC)
//     advance    : instruction accepted by decode; load the next PC
//     jump_en    : take jump_addr instead of pc + 4
//     jump_addr  : jump target
//     pc         : current fetch address
//   Build option IFU_MISALIGN_CHECK_EN: when defined, misaligned targets are
//   trapped by the top (advance is suppressed) so the target is loaded as is;
//   when undefined, the low two bits of the target are cleared on load.
module ysyx_23060332_ifu_pc
    import ysyx_23060332_ifu_pkg::*;
#(
    parameter logic [INST_ADDR_W-1:0] RESET_PC = PC_RESET
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   advance,
    input  logic                   jump_en,
    input  logic [INST_ADDR_W-1:0] jump_addr,
    output logic [INST_ADDR_W-1:0] pc
);

    logic [INST_ADDR_W-1:0] target;
    logic [INST_ADDR_W-1:0] pc_next;

`ifdef IFU_MISALIGN_CHECK_EN
    assign target = jump_addr;
`else
    assign target = jump_addr & ~INST_ADDR_W'(3);
`endif

    // pc + 4 wraps naturally at 32 bits (0xFFFF_FFFC -> 0x0000_0000).
    assign pc_next = jump_en ? target : pc + INST_ADDR_W'(4);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc <= RESET_PC;
        end else if (advance) begin
            pc <= pc_next;
        end
    end

endmodule

// File: rtl/ysyx_23060332_ifu.sv
// ysyx_23060332_ifu
//   Instruction fetch unit: owns the PC, fetches one 32-bit word per
//   instruction from imem and hands it with its address to decode.
//   Ports:
//     clk, rst_n : clock, asynchronous active-low reset
//     bus        : ysyx_23060332_ifu_if.master (imem request/response,
//                  inst channel, jump inputs, sticky fault status)
//     dbg_state  : current FSM state (ifu_state_e encoding)
//   Parameters:
//     RESET_PC : PC after reset
//     TIMEOUT  : wait cycles without a response before faulting (0 = never)
//   Build option IFU_MISALIGN_CHECK_EN: a taken jump to a non word-aligned
//   target faults instead of being silently aligned.
//   Sequence per instruction: REQ (request accepted) -> WAIT (response) ->
//   HOLD (decode accepts) -> REQ, i.e. at best one instruction per 3 cycles.
module ysyx_23060332_ifu
    import ysyx_23060332_ifu_pkg::*;
#(
    parameter logic [INST_ADDR_W-1:0] RESET_PC = PC_RESET,
    parameter int                     TIMEOUT  = 255
) (
    input  logic                     clk,
    input  logic                     rst_n,
    ysyx_23060332_ifu_if.master      bus,
    output logic [2:0]               dbg_state
);

    localparam int CNT_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
    // The wait that would bring the count to TIMEOUT is the one that faults.
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    ifu_state_e             state;
    logic                   req_valid_q;
    logic                   inst_valid_q;
    logic [INST_W-1:0]      inst_q;
    logic [INST_ADDR_W-1:0] inst_addr_q;
    logic                   fault_q;
    logic [INST_ADDR_W-1:0] fault_addr_q;
    logic [CNT_W-1:0]       wait_cnt;
    logic [INST_ADDR_W-1:0] pc;
    logic                   accept;
    logic                   misalign;
    logic                   pc_advance;

    assign accept = inst_valid_q && bus.inst_ready;

`ifdef IFU_MISALIGN_CHECK_EN
    assign misalign = bus.jump_en && is_misaligned(bus.jump_addr);
`else
    assign misalign = 1'b0;
`endif

    // A trapped jump must not move the PC.
    assign pc_advance = accept && !misalign;

    ysyx_23060332_ifu_pc #(
        .RESET_PC (RESET_PC)
    ) u_pc (
        .clk       (clk),
        .rst_n     (rst_n),
        .advance   (pc_advance),
        .jump_en   (bus.jump_en),
        .jump_addr (bus.jump_addr),
        .pc        (pc)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= IFU_S_IDLE;
            req_valid_q  <= 1'b0;
            inst_valid_q <= 1'b0;
            inst_q       <= INST_NOP;
            inst_addr_q  <= RESET_PC;
            fault_q      <= 1'b0;
            fault_addr_q <= '0;
            wait_cnt     <= '0;
        end else begin
            case (state)
                IFU_S_IDLE: begin
                    state       <= IFU_S_REQ;
                    req_valid_q <= 1'b1;
                end
                IFU_S_REQ: begin
                    if (bus.imem_req_ready) begin
                        state       <= IFU_S_WAIT;
                        req_valid_q <= 1'b0;
                        wait_cnt    <= '0;
                    end
                end
                IFU_S_WAIT: begin
                    if (bus.imem_resp_valid && !bus.imem_resp_err) begin
                        state        <= IFU_S_HOLD;
                        inst_q       <= bus.imem_resp_data;
                        inst_addr_q  <= pc;
                        inst_valid_q <= 1'b1;
                    end else if (bus.imem_resp_valid) begin
                        state        <= IFU_S_FAULT;
                        fault_q      <= 1'b1;
                        fault_addr_q <= pc;
                    end else if ((TIMEOUT != 0) && (wait_cnt == CNT_LAST)) begin
                        state        <= IFU_S_FAULT;
                        fault_q      <= 1'b1;
                        fault_addr_q <= pc;
                    end else begin
                        wait_cnt <= wait_cnt + CNT_W'(1);
                    end
                end
                IFU_S_HOLD: begin
                    if (accept) begin
                        inst_valid_q <= 1'b0;
                        if (misalign) begin
                            state        <= IFU_S_FAULT;
                            fault_q      <= 1'b1;
                            fault_addr_q <= bus.jump_addr;
                        end else begin
                            state       <= IFU_S_REQ;
                            req_valid_q <= 1'b1;
                        end
                    end
                end
                IFU_S_FAULT: begin
                    state        <= IFU_S_FAULT;
                    req_valid_q  <= 1'b0;
                    inst_valid_q <= 1'b0;
                    fault_q      <= 1'b1;
                end
                default: begin
                    state <= IFU_S_IDLE;
                end
            endcase
        end
    end

    assign bus.imem_req_valid = req_valid_q;
    assign bus.imem_req_addr  = pc;
    assign bus.inst_valid     = inst_valid_q;
    assign bus.inst_o         = inst_q;
    assign bus.inst_addr      = inst_addr_q;
    assign bus.fetch_fault    = fault_q;
    assign bus.fault_addr     = fault_addr_q;
    assign dbg_state          = state;

endmodule

// File: tb/tb_ysyx_23060332_ifu.sv
// tb_ysyx_23060332_ifu
//   Self-checking bench for ysyx_23060332_ifu (TIMEOUT = 4). A reference
//   model tracks the expected PC as "next = jump ? target : pc + 4", with
//   the misalignment rule applied according to IFU_MISALIGN_CHECK_EN.
module tb_ysyx_23060332_ifu;
    import ysyx_23060332_ifu_pkg::*;

    localparam logic [31:0] RST_PC = 32'h8000_0000;
    localparam int          TMO    = 4;

    logic       clk   = 1'b0;
    logic       rst_n = 1'b0;
    logic [2:0] dbg_state;

    ysyx_23060332_ifu_if bus ();

    ysyx_23060332_ifu #(
        .RESET_PC (RST_PC),
        .TIMEOUT  (TMO)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .bus       (bus),
        .dbg_state (dbg_state)
    );

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- scoreboard state ----------------
    int          checks = 0;
    int          errors = 0;
    logic [31:0] model_pc;
    logic [31:0] exp_q[$];

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%08h expected=%08h", tag, obs, exp);
        end
    endtask

    task automatic check1(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    // ---------------- reference model ----------------
    function automatic logic mis_fault(input logic jen, input logic [31:0] jaddr);
`ifdef IFU_MISALIGN_CHECK_EN
        return jen && ((jaddr % 4) != 0);
`else
        return 1'b0;
`endif
    endfunction

    function automatic logic [31:0] next_pc(input logic [31:0] pc, input logic jen,
                                            input logic [31:0] jaddr);
        if (jen) return jaddr - (jaddr % 4);
        return pc + 32'd4;
    endfunction

    // ---------------- driver tasks ----------------
    task automatic drive_idle;
        bus.imem_req_ready  = 1'b0;
        bus.imem_resp_valid = 1'b0;
        bus.imem_resp_data  = 32'h0;
        bus.imem_resp_err   = 1'b0;
        bus.inst_ready      = 1'b0;
        bus.jump_en         = 1'b0;
        bus.jump_addr       = 32'h0;
    endtask

    task automatic check_reset_vals(input string tag);
        check1({tag, "_req_valid"}, bus.imem_req_valid, 1'b0);
        check1({tag, "_inst_valid"}, bus.inst_valid, 1'b0);
        check({tag, "_inst_o"}, bus.inst_o, 32'h0000_0013);
        check({tag, "_inst_addr"}, bus.inst_addr, RST_PC);
        check1({tag, "_fault"}, bus.fetch_fault, 1'b0);
        check({tag, "_fault_addr"}, bus.fault_addr, 32'h0);
        check({tag, "_req_addr"}, bus.imem_req_addr, RST_PC);
        check({tag, "_state"}, {29'b0, dbg_state}, {29'b0, IFU_S_IDLE});
    endtask

    task automatic do_reset;
        drive_idle();
        rst_n = 1'b0;
        tick();
        tick();
        check_reset_vals("rst");
        rst_n    = 1'b1;
        model_pc = RST_PC;
        exp_q.delete();
    endtask

    // Wait (bounded) for a request, check its address, optionally stall,
    // then let it be accepted. Leaves the DUT in the response-wait phase.
    task automatic accept_req(input int req_stall);
        for (int i = 0; i < 10; i++) begin
            if (bus.imem_req_valid) break;
            tick();
        end
        check1("req_seen", bus.imem_req_valid, 1'b1);
        check("req_addr", bus.imem_req_addr, model_pc);
        for (int i = 0; i < req_stall; i++) begin
            bus.imem_req_ready  = 1'b0;
            bus.imem_resp_valid = 1'($urandom_range(0, 1));
            bus.imem_resp_data  = $urandom;
            tick();
            check1("req_hold_valid", bus.imem_req_valid, 1'b1);
            check("req_hold_addr", bus.imem_req_addr, model_pc);
        end
        bus.imem_resp_valid = 1'b0;
        bus.imem_req_ready  = 1'b1;
        tick();
        bus.imem_req_ready  = 1'b0;
        check1("req_drop", bus.imem_req_valid, 1'b0);
    endtask

    task automatic fetch_one(input logic [31:0] data, input int lat, input int req_stall,
                             input int hold_stall, input logic jen, input logic [31:0] jaddr);
        logic [31:0] exp_inst;
        accept_req(req_stall);
        for (int i = 0; i < lat; i++) begin
            bus.jump_en   = 1'($urandom_range(0, 1));
            bus.jump_addr = $urandom;
            tick();
            check1("wait_inst_valid", bus.inst_valid, 1'b0);
        end
        bus.jump_en         = 1'b0;
        bus.imem_resp_valid = 1'b1;
        bus.imem_resp_data  = data;
        bus.imem_resp_err   = 1'b0;
        exp_q.push_back(data);
        tick();
        bus.imem_resp_valid = 1'b0;
        exp_inst = exp_q.pop_front();
        check1("inst_valid", bus.inst_valid, 1'b1);
        check("inst_o", bus.inst_o, exp_inst);
        check("inst_addr", bus.inst_addr, model_pc);
        check1("hold_no_req", bus.imem_req_valid, 1'b0);
        for (int i = 0; i < hold_stall; i++) begin
            bus.inst_ready = 1'b0;
            bus.jump_en    = 1'($urandom_range(0, 1));
            bus.jump_addr  = $urandom;
            tick();
            check1("bp_inst_valid", bus.inst_valid, 1'b1);
            check("bp_inst_o", bus.inst_o, exp_inst);
            check("bp_inst_addr", bus.inst_addr, model_pc);
            check1("bp_no_req", bus.imem_req_valid, 1'b0);
        end
        bus.inst_ready = 1'b1;
        bus.jump_en    = jen;
        bus.jump_addr  = jaddr;
        tick();
        bus.inst_ready = 1'b0;
        bus.jump_en    = 1'b0;
        check1("acc_inst_valid", bus.inst_valid, 1'b0);
        if (mis_fault(jen, jaddr)) begin
            check1("mis_fault", bus.fetch_fault, 1'b1);
            check("mis_fault_addr", bus.fault_addr, jaddr);
            check1("mis_no_req", bus.imem_req_valid, 1'b0);
        end else begin
            model_pc = next_pc(model_pc, jen, jaddr);
            check1("next_req_valid", bus.imem_req_valid, 1'b1);
            check("next_req_addr", bus.imem_req_addr, model_pc);
            check1("no_fault", bus.fetch_fault, 1'b0);
        end
    endtask

    // ---------------- directed + random sequence ----------------
    initial begin
        logic [31:0] ja;
        drive_idle();
        model_pc = RST_PC;

        // Reset values, then a plain fetch with zero-wait memory.
        do_reset();
        fetch_one(32'h0010_0093, 0, 0, 0, 1'b0, 32'h0);

        // Decode backpressure for 5 cycles.
        fetch_one($urandom, 0, 0, 5, 1'b0, 32'h0);

        // Taken jump.
        fetch_one($urandom, 0, 0, 0, 1'b1, 32'h8000_0100);

        // Misaligned jump target.
        fetch_one($urandom, 1, 1, 0, 1'b1, 32'h8000_0102);
        if (mis_fault(1'b1, 32'h8000_0102)) do_reset();

        // PC wrap at the top of the address space.
        fetch_one($urandom, 0, 0, 0, 1'b1, 32'hFFFF_FFFC);
        fetch_one($urandom, 0, 0, 0, 1'b0, 32'h0);
        check("wrap_pc", model_pc, 32'h0000_0000);

        // Random traffic.
        for (int n = 0; n < 16; n++) begin
            ja = $urandom;
`ifdef IFU_MISALIGN_CHECK_EN
            ja = ja - (ja % 4);
`endif
            fetch_one($urandom, $urandom_range(0, 3), $urandom_range(0, 2),
                      $urandom_range(0, 3), 1'($urandom_range(0, 1)), ja);
        end

        // Access error on the third fetch (pc 0x8000_0008).
        do_reset();
        fetch_one($urandom, 0, 0, 0, 1'b0, 32'h0);
        fetch_one($urandom, 0, 0, 0, 1'b0, 32'h0);
        accept_req(0);
        bus.imem_resp_valid = 1'b1;
        bus.imem_resp_err   = 1'b1;
        bus.imem_resp_data  = $urandom;
        tick();
        bus.imem_resp_valid = 1'b0;
        bus.imem_resp_err   = 1'b0;
        check1("err_fault", bus.fetch_fault, 1'b1);
        check("err_fault_addr", bus.fault_addr, 32'h8000_0008);
        check1("err_no_inst", bus.inst_valid, 1'b0);
        check({29'b0, dbg_state} == {29'b0, IFU_S_FAULT} ? "err_state" : "err_state", {29'b0, dbg_state}, {29'b0, IFU_S_FAULT});
        for (int i = 0; i < 5; i++) begin
            bus.imem_req_ready = 1'b1;
            bus.inst_ready     = 1'b1;
            bus.jump_en        = 1'($urandom_range(0, 1));
            tick();
            check1("err_no_req", bus.imem_req_valid, 1'b0);
            check1("err_sticky", bus.fetch_fault, 1'b1);
        end
        drive_idle();

        // Timeout: no response for TMO wait cycles.
        do_reset();
        accept_req(0);
        for (int i = 1; i < TMO; i++) begin
            tick();
            check1("tmo_not_yet", bus.fetch_fault, 1'b0);
        end
        tick();
        check1("tmo_fault", bus.fetch_fault, 1'b1);
        check("tmo_fault_addr", bus.fault_addr, RST_PC);
        check1("tmo_no_req", bus.imem_req_valid, 1'b0);

        // Asynchronous reset while waiting for a response.
        do_reset();
        fetch_one(32'hDEAD_BEEF, 0, 0, 0, 1'b0, 32'h0);
        accept_req(0);
        tick();
        rst_n = 1'b0;
        #1;
        check_reset_vals("async");
        tick();
        tick();
        rst_n               = 1'b1;
        bus.imem_resp_valid = 1'b1;
        bus.imem_resp_data  = 32'h1234_5678;
        tick();
        bus.imem_resp_valid = 1'b0;
        check1("late_resp_ignored", bus.inst_valid, 1'b0);
        model_pc = RST_PC;
        exp_q.delete();
        fetch_one($urandom, 0, 0, 0, 1'b0, 32'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
